// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder. It accepts one load or
// store at a time and performs a byte/halfword/word access with lane enables and
// load extension. It answers with a one-cycle response strobe after WAIT_CYCLES
// wait states, so a pipelined CPU can be run against a stalling memory.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_w,
   input  logic [31:0] Addr_in,
   input  logic [31:0] Wdata_in,
   input  logic [2:0]  dm_ctrl,
   output logic        rsp_valid,
   output logic [31:0] Rdata_out,
   output logic        misalign
);

   localparam int         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [3:0]  wait_cnt;

   // Request captured at acceptance; port changes after that are not seen.
   logic        cap_w;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [2:0]  cap_ctrl;

   // Fields used for the access on the edge that enters RESP.
   logic        acc_w;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [2:0]  acc_ctrl;

   logic             is_half;
   logic             is_byte;
   logic             is_signed;
   logic             mis;
   logic [IDX_W-1:0] idx;
   logic [3:0]       lane_en;
   logic [31:0]      lane_data;
   logic [31:0]      rd_word;
   logic [15:0]      rd_half;
   logic [7:0]       rd_byte;
   logic [31:0]      ld_data;
   logic             enter_resp;
   logic             accept;
   logic             unused_addr_hi;

   logic [31:0] mem [DEPTH_WORDS];

   assign accept     = (state == S_IDLE) && req_valid;
   assign enter_resp = (state_nx == S_RESP) && !reset;

   // Next-state and handshake outputs.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it
      // unassigned; a missing default would infer a latch.
      state_nx  = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt == 4'd1) state_nx = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State register and wait-state counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block ordering.
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_nx;
         if (accept)                wait_cnt <= WAIT_INIT;
         else if (state == S_WAIT)  wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Capture the request fields on acceptance; pure datapath, no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         cap_w     <= mem_w;
         cap_addr  <= Addr_in;
         cap_wdata <= Wdata_in;
         cap_ctrl  <= dm_ctrl;
      end
   end

   // Access decode: width, misalignment, store lanes and load extraction.
   always_comb begin
      // A zero-wait request enters RESP on its own acceptance edge, so it is
      // served straight from the ports; otherwise the captured copy is used.
      if (WAIT_CYCLES == 0 && state == S_IDLE) begin
         acc_w     = mem_w;
         acc_addr  = Addr_in;
         acc_wdata = Wdata_in;
         acc_ctrl  = dm_ctrl;
      end else begin
         acc_w     = cap_w;
         acc_addr  = cap_addr;
         acc_wdata = cap_wdata;
         acc_ctrl  = cap_ctrl;
      end

      // Codes 101..111 fall through to word.
      is_half   = (acc_ctrl == 3'b001) || (acc_ctrl == 3'b010);
      is_byte   = (acc_ctrl == 3'b011) || (acc_ctrl == 3'b100);
      is_signed = (acc_ctrl == 3'b001) || (acc_ctrl == 3'b011);

      if (is_half)      mis = acc_addr[0];
      else if (is_byte) mis = 1'b0;
      else              mis = (acc_addr[1:0] != 2'b00);

      // Upper address bits beyond the array are ignored, so addresses wrap.
      idx = acc_addr[IDX_W+1:2];

      if (is_half) begin
         lane_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
         lane_data = {2{acc_wdata[15:0]}};
      end else if (is_byte) begin
         lane_en   = 4'b0001 << acc_addr[1:0];
         lane_data = {4{acc_wdata[7:0]}};
      end else begin
         lane_en   = 4'b1111;
         lane_data = acc_wdata;
      end

      rd_word = mem[idx];
      rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
      rd_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];

      if (is_half)
         ld_data = is_signed ? {{16{rd_half[15]}}, rd_half} : {16'h0000, rd_half};
      else if (is_byte)
         ld_data = is_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'h000000, rd_byte};
      else
         ld_data = rd_word;
   end

   assign unused_addr_hi = &{1'b0, acc_addr[31:IDX_W+2]};

   // Response data: registered on entry to RESP, held one cycle, zero otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         Rdata_out <= '0;
         misalign  <= 1'b0;
      end else if (enter_resp) begin
         Rdata_out <= (acc_w || mis) ? 32'h0 : ld_data;
         misalign  <= mis;
      end else begin
         Rdata_out <= '0;
         misalign  <= 1'b0;
      end
   end

   // Store commit with per-byte lane enables on the edge that enters RESP.
   always_ff @(posedge clk) begin
      // NOTE: the array is intentionally not reset; contents survive reset and a
      // reset would also prevent mapping onto RAM macros.
      if (enter_resp && acc_w && !mis) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
         end
      end
   end

endmodule
